// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared widths, read-engine FSM states and descriptor type
package switch_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 17;
    localparam int LEN_WIDTH  = 8;
    localparam int PRI_WIDTH  = 3;
    localparam int BUF_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [PRI_WIDTH-1:0]  pri;
    } desc_t;

endpackage

// File: rtl/rd_data_fifo.sv
// rtl/rd_data_fifo.sv - synchronous read-data FIFO between SRAM return and output beats
// Purpose: holds SRAM words until the output side accepts them; no bypass path.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         write push_data_i this cycle
//   pop_i          drop head this cycle (ignored when empty)
//   head_o         oldest stored word
//   count_o        current occupancy, 0..DEPTH
//   empty_o/full_o occupancy flags
module rd_data_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     pop_i,
    output logic [DATA_WIDTH-1:0]    head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_C = DEPTH[PTR_W:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_C);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push on a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pkt_read_engine.sv
// rtl/pkt_read_engine.sv - per-port packet read engine: descriptor in, SRAM fetch, output beats
// Purpose: accepts one descriptor, reads the packet word by word over the shared SRAM
// read port and streams it out with sop/eop framing under output backpressure.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   desc_vld/desc_rdy, desc_addr/len/pri  descriptor handshake from cache_manager
//   busy                              packet in progress
//   sram_req/sram_addr/sram_gnt/sram_dout  SRAM read port (data one cycle after grant)
//   rd_ready/rd_vld/rd_sop/rd_eop/rd_data/rd_pri  output beat interface
//   err_len                           one-cycle pulse when a zero-length descriptor is dropped
module pkt_read_engine #(
    parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = switch_pkg::ADDR_WIDTH,
    parameter int LEN_WIDTH  = switch_pkg::LEN_WIDTH,
    parameter int PRI_WIDTH  = switch_pkg::PRI_WIDTH,
    parameter int BUF_DEPTH  = switch_pkg::BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_vld,
    input  logic [ADDR_WIDTH-1:0] desc_addr,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    input  logic [PRI_WIDTH-1:0]  desc_pri,
    output logic                  desc_rdy,
    output logic                  busy,
    output logic                  sram_req,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic                  sram_gnt,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    input  logic                  rd_ready,
    output logic                  rd_vld,
    output logic                  rd_sop,
    output logic                  rd_eop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [PRI_WIDTH-1:0]  rd_pri,
    output logic                  err_len
);

    import switch_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = BUF_DEPTH[CNT_W:0];

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [PRI_WIDTH-1:0]  pri_q, pri_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  emit_cnt_q, emit_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  err_len_q, err_len_d;
    logic                  out_en_q;

    logic [CNT_W-1:0]      buf_count;
    logic [DATA_WIDTH-1:0] buf_head;
    logic                  buf_empty, buf_full, buf_pop;
    logic [CNT_W:0]        committed;
    logic                  req, gnt, accept;

    // Words already buffered plus the one still on its way back from SRAM;
    // requesting only below BUF_DEPTH means the FIFO can never overflow.
    assign committed = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q};
    assign req       = (state_q == FETCH) && (issue_cnt_q != '0) && !buf_full
                       && (committed < DEPTH_C);
    assign gnt       = req && sram_gnt;
    assign accept    = desc_vld && desc_rdy;
    assign buf_pop   = rd_vld && rd_ready;

    rd_data_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (inflight_q),
        .push_data_i (sram_dout),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .count_o     (buf_count),
        .empty_o     (buf_empty),
        .full_o      (buf_full)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        pri_d       = pri_q;
        issue_cnt_d = issue_cnt_q;
        emit_cnt_d  = emit_cnt_q;
        inflight_d  = gnt;
        err_len_d   = 1'b0;

        if (buf_pop) begin
            emit_cnt_d = emit_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (desc_len == '0) begin
                        err_len_d = 1'b1;
                    end else begin
                        addr_d      = desc_addr;
                        len_d       = desc_len;
                        pri_d       = desc_pri;
                        issue_cnt_d = desc_len;
                        emit_cnt_d  = desc_len;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (gnt) begin
                    addr_d      = addr_q + 1'b1;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                    if (issue_cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave on the eop transfer itself so desc_rdy rises the next cycle.
                if ((emit_cnt_q == '0) || (buf_pop && (emit_cnt_q == LEN_WIDTH'(1)))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            pri_q       <= '0;
            issue_cnt_q <= '0;
            emit_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            err_len_q   <= 1'b0;
            out_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            pri_q       <= pri_d;
            issue_cnt_q <= issue_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            inflight_q  <= inflight_d;
            err_len_q   <= err_len_d;
            out_en_q    <= 1'b1;
        end
    end

    // out_en_q keeps desc_rdy low while reset is held even though state_q is IDLE.
    assign desc_rdy  = out_en_q && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sram_req  = req;
    assign sram_addr = addr_q;
    assign rd_vld    = !buf_empty;
    assign rd_data   = buf_empty ? '0 : buf_head;
    assign rd_sop    = rd_vld && (emit_cnt_q == len_q);
    assign rd_eop    = rd_vld && (emit_cnt_q == LEN_WIDTH'(1));
    assign rd_pri    = pri_q;
    assign err_len   = err_len_q;

endmodule

// File: doc/pkt_read_engine.md
Name: pkt_read_engine

Overview:
Read-side counterpart to the SRAM write path (write_arbiter/datasg), one instance per output port.
- Accepts one packet descriptor (start address, length, priority) from cache_manager.
- Fetches the packet word by word through the shared SRAM read port (addrb/doutb).
- Emits the packet on the port's rd_sop/rd_vld/rd_eop/rd_data interface, with backpressure from the output side.
- Buffers SRAM read data in a small FIFO so that backpressure never loses a word.

Parameters:
DATA_WIDTH, 64, SRAM word / rd_data width
ADDR_WIDTH, 17, SRAM address width
LEN_WIDTH, 8, packet length field width, in words
PRI_WIDTH, 3, priority field width
BUF_DEPTH, 4, read-data buffer entries, power of two, at least 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
desc_vld  in  1  cache_manager holds a valid descriptor (port_n_prepared)
desc_addr  in  ADDR_WIDTH  packet start address
desc_len  in  LEN_WIDTH  packet length in words
desc_pri  in  PRI_WIDTH  packet priority
desc_rdy  out  1  descriptor accepted when desc_vld && desc_rdy (port_n_rea)
busy  out  1  packet in progress (port_n_reading)
sram_req  out  1  read request to the SRAM read arbiter
sram_addr  out  ADDR_WIDTH  read address, valid while sram_req is high
sram_gnt  in  1  request granted this cycle
sram_dout  in  DATA_WIDTH  read data, valid exactly 1 cycle after a granted request
rd_ready  in  1  output side accepts the current beat
rd_vld  out  1  beat valid
rd_sop  out  1  first beat of packet
rd_eop  out  1  last beat of packet
rd_data  out  DATA_WIDTH  beat data
rd_pri  out  PRI_WIDTH  priority of the packet in flight
err_len  out  1  one-cycle pulse: zero-length descriptor dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - FSM to IDLE; counters, buffer pointers and the in-flight flag cleared.
  - Any SRAM data returning after reset deassertion is ignored.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - desc_rdy=1. On desc_vld, latch addr, len and pri. The latched pri drives rd_pri.
  - Load issue_cnt=len and emit_cnt=len.
  - Go to FETCH next cycle.
  - If len==0: pulse err_len, consume the descriptor, stay in IDLE.
- FETCH:
  - sram_req=1 when issue_cnt>0 and (buf_occupancy + inflight) < BUF_DEPTH.
  - On sram_gnt: sram_addr increments by 1 (wraps modulo 2^ADDR_WIDTH), issue_cnt decrements, inflight set for the next cycle.
  - The cycle after a grant, sram_dout is written into the buffer.
  - When issue_cnt reaches 0, go to DRAIN.
- DRAIN: wait until emit_cnt==0, then return to IDLE. desc_rdy goes high the cycle after the eop beat is accepted.
- Output beats:
  - rd_vld=1 whenever the buffer is non-empty; rd_data is the buffer head.
  - A beat transfers on rd_vld && rd_ready; emit_cnt then decrements.
  - rd_sop=1 on the beat with emit_cnt==len.
  - rd_eop=1 on the beat with emit_cnt==1.
  - len==1 gives sop and eop on the same beat.
  - While rd_ready=0, rd_vld, rd_sop, rd_eop and rd_data hold stable.
- Latency:
  - Descriptor accepted at cycle T → sram_req at T+1.
  - If granted at T+1, data is captured at the end of T+2 and rd_vld=1 at T+3.
  - With rd_ready and sram_gnt held high, throughput is 1 beat/cycle.
- busy=1 from the cycle after descriptor acceptance until return to IDLE.
- Buffer:
  - Occupancy can never exceed BUF_DEPTH, by construction of the request rule.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Simultaneous push and pop is legal on the full buffer and on the empty buffer (the word is pushed then popped on a later cycle; no bypass).
- sram_gnt while sram_req=0 is ignored.
- desc_vld outside IDLE is ignored (desc_rdy=0).

Decomposition:
- Shared package (switch_pkg): DATA_WIDTH, ADDR_WIDTH, LEN_WIDTH and PRI_WIDTH constants; FSM state enum (IDLE/FETCH/DRAIN); descriptor struct {addr, len, pri}.
- One sub-module, rd_data_fifo: synchronous FIFO of BUF_DEPTH entries, each DATA_WIDTH wide. Provides push, pop, head data, occupancy, empty and full.

Test Plan:
- len=1 at addr 0x00010, mem[0x10]=0xA5, gnt/ready always 1 → one beat at T+3 with rd_sop=rd_eop=rd_vld=1, data 0xA5.
- len=4 at 0x00100, ready=1 → beats in 4 consecutive cycles: data mem[0x100..0x103], sop on beat 1, eop on beat 4. desc_rdy=1 the cycle after eop.
- len=8, rd_ready low for 5 cycles after beat 2 → sram_req drops once occupancy+inflight=4. Beat 3 held stable. All 8 words delivered in order with no loss or duplicate.
- len=4 at 0x1FFFE, sram_gnt toggling 1/0 → sram_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001. Each address is held until granted.
- len=0 descriptor → err_len pulses 1 cycle, no sram_req, no rd_vld, FSM stays in IDLE.
- rst asserted after beat 2 of a len=6 packet with a grant in flight → all outputs 0 immediately. After release: desc_rdy=1, no stale beat emitted, and the next len=2 packet is delivered correctly.
